// File: rtl/pp2pg_pkg.sv
// Shared constants and FSM encoding for the pp2pg read-side timing generator.
package pp2pg_pkg;

  localparam int CNT_W = 12;

  // 1080p60 raster
  localparam int DEF_H_ACTIVE = 1920;
  localparam int DEF_H_FP     = 88;
  localparam int DEF_H_SYNC   = 44;
  localparam int DEF_H_BP     = 148;
  localparam int DEF_V_ACTIVE = 1080;
  localparam int DEF_V_FP     = 4;
  localparam int DEF_V_SYNC   = 5;
  localparam int DEF_V_BP     = 36;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/pp2pg_hv_cnt.sv
// Horizontal/vertical raster counters with active, sync and frame-origin decode.
// Origin (0,0) is the first active pixel; porches and syncs follow the active area.
module pp2pg_hv_cnt
  import pp2pg_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  input  logic i_clear,
  output logic o_act,
  output logic o_hs,
  output logic o_vs,
  output logic o_first,
  output logic o_frame_end
);

  localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOT - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOT - 1);
  localparam logic [CNT_W-1:0] H_ACT_N = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_N = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_BEG  = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END  = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_BEG  = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END  = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  logic             w_h_wrap;

  assign w_h_wrap = (r_h_cnt == H_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (i_clear) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (i_run) begin
      if (w_h_wrap) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + CNT_W'(1);
      end else begin
        r_h_cnt <= r_h_cnt + CNT_W'(1);
      end
    end
  end

  // vs decodes from v_cnt only, so it can only change as h_cnt wraps to 0
  assign o_act       = (r_h_cnt < H_ACT_N) && (r_v_cnt < V_ACT_N);
  assign o_hs        = (r_h_cnt >= HS_BEG) && (r_h_cnt < HS_END);
  assign o_vs        = (r_v_cnt >= VS_BEG) && (r_v_cnt < VS_END);
  assign o_first     = (r_h_cnt == '0) && (r_v_cnt == '0);
  assign o_frame_end = w_h_wrap && (r_v_cnt == V_LAST);

endmodule

// File: rtl/pp2pg_timing_gen.sv
// Drains pixel words from the pg2pp FIFO and regenerates a continuous Vs/Hs/DE raster.
// FIFO underruns substitute black pixels without disturbing timing.
module pp2pg_timing_gen
  import pp2pg_pkg::*;
#(
  parameter int RGB_PORT = 1,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input  logic                     rd_clk,
  input  logic                     rst_n,
  input  logic                     enable,
  input  logic                     fifo_empty,
  input  logic [RGB_PORT*24-1:0]   fifo_dout,
  output logic                     fifo_rd_en,
  output logic                     Vs_out,
  output logic                     Hs_out,
  output logic                     De_out,
  output logic [RGB_PORT*24-1:0]   Dout,
  output logic                     frame_start,
  output logic                     underrun,
  output logic                     busy
);

  localparam int DW = RGB_PORT * 24;

  state_t          r_state;
  logic            r_stop_req;
  logic            r_underrun;
  logic            r_busy;

  logic            w_run;
  logic            w_act;
  logic            w_hs;
  logic            w_vs;
  logic            w_first;
  logic            w_frame_end;
  logic            w_rd_en;

  logic            r_a_act;
  logic            r_a_hs;
  logic            r_a_vs;
  logic            r_a_first;
  logic            r_a_taken;

  logic [DW-1:0]   r_dout;
  logic            r_de;
  logic            r_hs;
  logic            r_vs;
  logic            r_fs;

  assign w_run   = (r_state == RUN);
  assign w_rd_en = w_run && w_act && !fifo_empty;

  pp2pg_hv_cnt #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_hv_cnt (
    .i_clk       (rd_clk),
    .i_rst_n     (rst_n),
    .i_run       (w_run),
    .i_clear     (!w_run),
    .o_act       (w_act),
    .o_hs        (w_hs),
    .o_vs        (w_vs),
    .o_first     (w_first),
    .o_frame_end (w_frame_end)
  );

  // A stop request only takes effect at the last counter position, so frames are never cut short
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_stop_req <= 1'b0;
      r_underrun <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (enable) begin
            r_state    <= WAIT;
            r_busy     <= 1'b1;
            r_underrun <= 1'b0;
          end
        end
        WAIT: begin
          if (!enable) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end else if (!fifo_empty) begin
            r_state    <= RUN;
            r_stop_req <= 1'b0;
          end
        end
        RUN: begin
          if (w_frame_end && r_stop_req) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_stop_req <= 1'b0;
          end else begin
            r_stop_req <= !enable;
          end
          if (w_act && fifo_empty) begin
            r_underrun <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  // Stage A aligns decode with the FIFO's one-cycle read latency; stage B drives the pins
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_act   <= 1'b0;
      r_a_hs    <= 1'b0;
      r_a_vs    <= 1'b0;
      r_a_first <= 1'b0;
      r_a_taken <= 1'b0;
      r_dout    <= '0;
      r_de      <= 1'b0;
      r_hs      <= !HS_POL;
      r_vs      <= !VS_POL;
      r_fs      <= 1'b0;
    end else begin
      r_a_act   <= w_run && w_act;
      r_a_hs    <= w_run && w_hs;
      r_a_vs    <= w_run && w_vs;
      r_a_first <= w_run && w_first;
      r_a_taken <= w_rd_en;
      r_dout    <= r_a_taken ? fifo_dout : '0;
      r_de      <= r_a_act;
      r_hs      <= r_a_hs ? HS_POL : !HS_POL;
      r_vs      <= r_a_vs ? VS_POL : !VS_POL;
      r_fs      <= r_a_first;
    end
  end

  assign fifo_rd_en  = w_rd_en;
  assign Vs_out      = r_vs;
  assign Hs_out      = r_hs;
  assign De_out      = r_de;
  assign Dout        = r_dout;
  assign frame_start = r_fs;
  assign underrun    = r_underrun;
  assign busy        = r_busy;

endmodule

// File: tb/tb_pp2pg_timing_gen.sv
// Directed bench for pp2pg_timing_gen on a 8x6 raster (4x3 active, 48 clocks per frame).
module tb_pp2pg_timing_gen;

  logic        rd_clk;
  logic        rst_n;
  logic        enable;
  logic        fifo_empty;
  logic [23:0] fifo_dout;
  logic        fifo_rd_en;
  logic        Vs_out;
  logic        Hs_out;
  logic        De_out;
  logic [23:0] Dout;
  logic        frame_start;
  logic        underrun;
  logic        busy;

  int totalChecks = 0;
  int badChecks   = 0;
  int cyc         = 0;

  logic [23:0] fifoMem [0:255];
  int          wrPtr = 0;
  int          rdPtr = 0;

  logic        logRd   [0:2047];
  logic        logDe   [0:2047];
  logic        logHs   [0:2047];
  logic        logVs   [0:2047];
  logic        logFs   [0:2047];
  logic        logUr   [0:2047];
  logic        logBusy [0:2047];
  logic [23:0] logDout [0:2047];

  pp2pg_timing_gen #(
    .RGB_PORT (1),
    .H_ACTIVE (4),
    .H_FP     (1),
    .H_SYNC   (2),
    .H_BP     (1),
    .V_ACTIVE (3),
    .V_FP     (1),
    .V_SYNC   (1),
    .V_BP     (1),
    .HS_POL   (1'b1),
    .VS_POL   (1'b1)
  ) dut (
    .rd_clk      (rd_clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .fifo_empty  (fifo_empty),
    .fifo_dout   (fifo_dout),
    .fifo_rd_en  (fifo_rd_en),
    .Vs_out      (Vs_out),
    .Hs_out      (Hs_out),
    .De_out      (De_out),
    .Dout        (Dout),
    .frame_start (frame_start),
    .underrun    (underrun),
    .busy        (busy)
  );

  initial begin
    rd_clk = 1'b0;
    forever #5 rd_clk = ~rd_clk;
  end

  always @(posedge rd_clk) cyc <= cyc + 1;

  // Standard-mode FIFO model: data appears the cycle after the read strobe
  assign fifo_empty = (wrPtr == rdPtr);
  initial fifo_dout = '0;
  always @(posedge rd_clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= fifoMem[rdPtr % 256];
      rdPtr     <= rdPtr + 1;
    end
  end

  always @(negedge rd_clk) begin
    if (cyc < 2048) begin
      logRd[cyc]   <= fifo_rd_en;
      logDe[cyc]   <= De_out;
      logHs[cyc]   <= Hs_out;
      logVs[cyc]   <= Vs_out;
      logFs[cyc]   <= frame_start;
      logUr[cyc]   <= underrun;
      logBusy[cyc] <= busy;
      logDout[cyc] <= Dout;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    totalChecks++;
    if (observed !== expected) begin
      badChecks++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic rstN);
    enable = en;
    rst_n  = rstN;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  task automatic waitUntil(input int target);
    int guard = 0;
    while (cyc < target && guard < 5000) begin
      waitCycles(1);
      guard++;
    end
  endtask

  task automatic waitRdEn(input int limit, output int t);
    int n = 0;
    while (fifo_rd_en !== 1'b1 && n < limit) begin
      waitCycles(1);
      n++;
    end
    if (fifo_rd_en !== 1'b1) checkOutput("rdTimeout", 32'd0, 32'd1);
    t = cyc;
  endtask

  task automatic pushWords(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      fifoMem[wrPtr % 256] = 24'(base + i);
      wrPtr = wrPtr + 1;
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ctl"},
                {25'd0, Vs_out, Hs_out, De_out, frame_start, underrun, busy, fifo_rd_en}, 32'd0);
    checkOutput({tag, "_dout"}, {8'd0, Dout}, 32'd0);
  endtask

  // Expected raster for one frame starting with counters at (0,0) on cycle t0
  task automatic checkFrame(input int t0, input int base, input int nWords, input string tag);
    for (int k = 0; k < 48; k++) begin
      int  h   = k % 8;
      int  v   = k / 8;
      int  pix = v * 4 + h;
      logic act = (h < 4) && (v < 3);
      logic rdExp = act && (pix < nWords);
      logic [3:0] ctlExp = {act, (h == 5) || (h == 6), v == 4, k == 0};
      logic [23:0] dExp = rdExp ? 24'(base + pix) : 24'd0;
      checkOutput($sformatf("%s_rd%0d", tag, k), {31'd0, logRd[t0 + k]}, {31'd0, rdExp});
      checkOutput($sformatf("%s_ctl%0d", tag, k),
                  {28'd0, logDe[t0 + k + 2], logHs[t0 + k + 2], logVs[t0 + k + 2], logFs[t0 + k + 2]},
                  {28'd0, ctlExp});
      checkOutput($sformatf("%s_dout%0d", tag, k), {8'd0, logDout[t0 + k + 2]}, {8'd0, dExp});
    end
  endtask

  initial begin
    int e, t0, t1, t2, r, p, q, noisy, busyCnt, urCnt, rdAfter;

    applyStimulus(1'b0, 1'b0);
    @(posedge rd_clk);
    #1;
    waitCycles(2);
    checkResetValues("reset");

    // Full frame with 12 preloaded words, then the second frame underruns
    pushWords(1, 12);
    applyStimulus(1'b0, 1'b1);
    waitCycles(2);
    e = cyc;
    applyStimulus(1'b1, 1'b1);
    waitRdEn(10, t0);
    checkOutput("t1latency", 32'(t0 - e), 32'd2);
    waitUntil(t0 + 56);
    checkFrame(t0, 1, 12, "t1f1");
    checkOutput("t2periodFs", {31'd0, logFs[t0 + 50]}, 32'd1);
    checkOutput("t2gapFs", {31'd0, logFs[t0 + 49]}, 32'd0);
    checkOutput("t1urFrame2", {31'd0, underrun}, 32'd1);

    // Only 10 words: pixels 11 and 12 go black, timing carries on into an empty frame
    applyStimulus(1'b0, 1'b0);
    #1;
    checkResetValues("t3rst");
    waitCycles(2);
    wrPtr = rdPtr;
    pushWords(32'h21, 10);
    applyStimulus(1'b0, 1'b1);
    waitCycles(1);
    applyStimulus(1'b1, 1'b1);
    waitRdEn(10, t0);
    waitUntil(t0 + 100);
    checkFrame(t0, 32'h21, 10, "t3f1");
    checkFrame(t0 + 48, 0, 0, "t3f2");
    checkOutput("t3urBefore", {31'd0, logUr[t0 + 18]}, 32'd0);
    checkOutput("t3urRise", {31'd0, logUr[t0 + 19]}, 32'd1);
    checkOutput("t3urSticky", {31'd0, logUr[t0 + 95]}, 32'd1);

    // Drop enable at pixel 5: frame completes, then idle
    applyStimulus(1'b0, 1'b0);
    waitCycles(2);
    wrPtr = rdPtr;
    pushWords(32'h41, 11);
    applyStimulus(1'b0, 1'b1);
    waitCycles(1);
    applyStimulus(1'b1, 1'b1);
    waitRdEn(10, t0);
    waitUntil(t0 + 8);
    applyStimulus(1'b0, 1'b1);
    waitUntil(t0 + 60);
    checkFrame(t0, 32'h41, 11, "t4f");
    checkOutput("t4busyLast", {31'd0, logBusy[t0 + 47]}, 32'd1);
    checkOutput("t4busyFall", {31'd0, logBusy[t0 + 48]}, 32'd0);
    rdAfter = 0;
    for (int c = t0 + 48; c < t0 + 60; c++) rdAfter += int'(logRd[c]);
    checkOutput("t4noRdAfter", 32'(rdAfter), 32'd0);

    // Re-enable into an empty FIFO: underrun clears and the block waits quietly
    r = cyc;
    applyStimulus(1'b1, 1'b1);
    waitUntil(r + 21);
    checkOutput("t4urHeld", {31'd0, logUr[r]}, 32'd1);
    checkOutput("t4urClear", {31'd0, logUr[r + 1]}, 32'd0);
    noisy = 0;
    busyCnt = 0;
    urCnt = 0;
    for (int c = r + 1; c <= r + 20; c++) begin
      if (logRd[c] || logDe[c] || logHs[c] || logVs[c] || logFs[c] || (logDout[c] != 24'd0)) noisy++;
      busyCnt += int'(logBusy[c]);
      urCnt   += int'(logUr[c]);
    end
    checkOutput("t5quiet", 32'(noisy), 32'd0);
    checkOutput("t5busyWait", 32'(busyCnt), 32'd20);
    checkOutput("t5urZero", 32'(urCnt), 32'd0);
    pushWords(32'h51, 12);
    checkOutput("t5preRd", {31'd0, fifo_rd_en}, 32'd0);
    waitCycles(1);
    checkOutput("t5startRd", {31'd0, fifo_rd_en}, 32'd1);
    t1 = cyc;

    // Asynchronous reset at line 1, pixel 2, then a clean restart from the origin
    waitUntil(t1 + 10);
    checkOutput("t6preRd", {31'd0, fifo_rd_en}, 32'd1);
    applyStimulus(1'b1, 1'b0);
    #1;
    checkResetValues("t6async");
    waitCycles(3);
    checkOutput("t6heldRd", {31'd0, fifo_rd_en}, 32'd0);
    wrPtr = rdPtr;
    pushWords(32'h61, 12);
    q = cyc;
    applyStimulus(1'b1, 1'b1);
    waitRdEn(10, t2);
    checkOutput("t6latency", 32'(t2 - q), 32'd2);
    waitUntil(t2 + 52);
    checkFrame(t2, 32'h61, 12, "t6f");
    p = 0;

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/pp2pg_timing_gen.md
Name: pp2pg_timing_gen

Overview:
- Read-side counterpart of the pg2pp write path: drains pixel words from the pg2pp FIFO and regenerates a continuous raster with Vsync/Hsync/DE timing.
- Runs entirely on the FIFO read clock and owns fifo_rd_en.
- Raster geometry is fixed by parameters. A FIFO underrun never breaks timing; it substitutes black pixels and raises a sticky flag.

Parameters:
- RGB_PORT, 1: number of 24-bit pixels per word; data width = RGB_PORT*24.
- H_ACTIVE, 1920: active pixels per line.
- H_FP, 88: horizontal front porch, in clocks.
- H_SYNC, 44: Hsync width, in clocks.
- H_BP, 148: horizontal back porch, in clocks.
- V_ACTIVE, 1080: active lines per frame.
- V_FP, 4: vertical front porch, in lines.
- V_SYNC, 5: Vsync width, in lines.
- V_BP, 36: vertical back porch, in lines.
- HS_POL, 1: Hsync active level.
- VS_POL, 1: Vsync active level.
- Widths: h_cnt and v_cnt are 12 bits each.

Ports:
- rd_clk, in, 1: single clock domain (FIFO read clock).
- rst_n, in, 1: asynchronous, active-low reset.
- enable, in, 1: run request.
- fifo_empty, in, 1: FIFO empty flag.
- fifo_dout, in, RGB_PORT*24: FIFO read data, valid 1 cycle after fifo_rd_en (standard-mode FIFO).
- fifo_rd_en, out, 1: FIFO read strobe.
- Vs_out, out, 1: vertical sync.
- Hs_out, out, 1: horizontal sync.
- De_out, out, 1: data enable.
- Dout, out, RGB_PORT*24: pixel data.
- frame_start, out, 1: 1-cycle pulse coincident with the first De_out of each frame.
- underrun, out, 1: sticky underrun flag.
- busy, out, 1: high when the state is not IDLE.

Behaviour:
- Reset values:
  - All registers are cleared; state = IDLE; h_cnt = 0; v_cnt = 0.
  - Vs_out = !VS_POL; Hs_out = !HS_POL; De_out = 0; Dout = 0.
  - frame_start = 0; underrun = 0; busy = 0; fifo_rd_en = 0.
- Counters:
  - h_cnt counts 0..H_TOT-1, where H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP.
  - v_cnt increments when h_cnt wraps and counts 0..V_TOT-1, wrapping to 0.
  - Origin (0,0) is the first active pixel of the frame.
- Decode from counters:
  - act = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - hs = h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC).
  - vs = v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); vs changes only when h_cnt = 0.
- fifo_rd_en is combinational: fifo_rd_en = (state == RUN) && act && !fifo_empty.
- Pipeline (output latency is exactly 2 clocks from counter position to output pins):
  - Stage A registers act, hs, vs, first-pixel, and a rd_en-taken bit.
  - Stage B registers the outputs:
    - Dout = A.taken ? fifo_dout : 0.
    - De_out = A.act.
    - Hs_out/Vs_out are hs/vs XOR'd to the configured polarity.
  - All outputs are registered.
- State machine:
  - IDLE:
    - Counters are held at 0 and the raster outputs are at their inactive levels.
    - enable=1 → WAIT.
    - Entering WAIT clears underrun.
  - WAIT:
    - Counters stay held.
    - !fifo_empty → RUN, with counters starting at (0,0) on the next cycle.
    - enable=0 → IDLE.
  - RUN:
    - Counters free-run.
    - enable=0 is latched as stop_req. When h_cnt = H_TOT-1 and v_cnt = V_TOT-1 with stop_req set → IDLE; stop_req is cleared.
    - A frame is never truncated.
  - After returning to IDLE, the 2 in-flight pipeline stages still drain to the outputs.
- Underrun:
  - In RUN with act=1 and fifo_empty=1: no read; that pixel outputs Dout = 0 while De_out stays 1.
  - underrun is set and held until the next IDLE→WAIT transition.
  - Timing continues unchanged; there is no re-synchronisation.
- Simultaneous events:
  - enable falling in the same cycle as the WAIT→RUN condition: IDLE wins.
  - enable re-asserted while stop_req is pending cancels stop_req.
- Asynchronous reset mid-frame: every output returns immediately to its reset value and no further FIFO reads occur.
- frame_start: asserted at the stage-B output for pixel (0,0).

Decomposition:
- Package pp2pg_pkg:
  - State encoding: IDLE=2'd0, WAIT=2'd1, RUN=2'd2.
  - Default timing constants (1080p60 set).
  - Counter width constant CNT_W=12.
- One sub-module, pp2pg_hv_cnt: H/V counters plus act/hs/vs/first decode, with inputs run and clear.
- The FSM, read control and the 2-stage pipeline stay in the top module.

Test Plan (small raster: H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1; 48 clocks per frame, 12 pixels):
1. Reset, then enable=1 with the FIFO preloaded with 12 words 0x000001..0x00000C.
   - fifo_rd_en pulses exactly 12 times per frame.
   - De_out high 4 clocks per line × 3 lines, Dout in the order 1..C.
   - frame_start 2 clocks after the first fifo_rd_en.
2. Check timing shape on the same frame.
   - Hs_out active for 2 clocks starting 5 clocks after each line's first DE.
   - Vs_out active for exactly 8 clocks (line 4).
   - Period 48 clocks.
3. FIFO holds only 10 words.
   - Pixels 11 and 12 output Dout=0 with De_out=1.
   - underrun rises and stays 1.
   - Next frame timing is still at period 48.
4. Drop enable at pixel 5 of frame 1.
   - Frame completes: all 12 DE cycles present.
   - busy falls after the last counter cycle.
   - No fifo_rd_en after that.
   - Re-enable clears underrun.
5. enable=1 with the FIFO empty for 20 clocks.
   - State stays WAIT, no outputs toggle, underrun=0.
   - Raster starts 1 clock after fifo_empty falls.
6. Assert rst_n low mid-line (pixel 2, line 1).
   - Outputs go to their reset values asynchronously and fifo_rd_en=0.
   - After release with enable=1, the restart is clean from (0,0).
